serial_addsub: RTL
==================

Name: serial_addsub

Overview:
Multi-cycle N-bit adder/subtractor. It consumes its operands in 2-bit slices, LSB slice first, one slice per clock, and uses a single carry flip-flop between slices. The start/busy/done handshake lets a controller issue one operation at a time. The block is the sequential, wide-operand counterpart to the lab's combinational 2-bit add/sub slice, and sits between the operand registers and the result display or register file.

Parameters:
WIDTH, 8, operand and result width in bits; must be even and >= 2.
SLICES (local), WIDTH/2, number of 2-bit slices, which equals the number of RUN cycles.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous reset, active-low.
start  input  1  request a new operation; sampled only in IDLE.
sub  input  1  0 = a+b, 1 = a-b; captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle on.
result  output  WIDTH  sum or difference, modulo 2^WIDTH.
cout  output  1  carry out of the MSB. For sub this is NOT borrow: 1 means a >= b unsigned.
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge) overrides everything, including mid-operation:
  - state goes to IDLE;
  - busy, done, cout, ovf = 0; result = 0;
  - the carry register and slice counter clear.
- States:
  - IDLE: busy=0. If start=1 at an edge: latch a, b and sub; set carry = sub; set slice index = 0; go to RUN.
  - RUN: busy=1. Each edge processes slice i = bits [2i+1:2i].
    - bb = b slice XOR {2{sub}}.
    - {c, s} = a slice + bb + carry.
    - Write s into result[2i+1:2i] and store c in the carry register.
    - i increments. After slice SLICES-1 is processed, go to DONE.
  - DONE: busy=1 and done=1 for exactly one cycle, then go to IDLE.
- cout = final carry; it is registered on the same edge as the last slice.
- ovf = carry into the MSB XOR carry out of the MSB. The MSB is bit 1 of the last slice.
- Latency: start sampled at edge E0 → last slice written at edge E(SLICES) → done high in the cycle after E(SLICES) → IDLE after the next edge. Total SLICES+1 cycles from start to done; WIDTH=8 gives done 5 cycles after start.
- start while busy (RUN or DONE) is ignored; a, b and sub changes during busy have no effect.
- A start is accepted only in IDLE, so the minimum spacing between operations is SLICES+2 cycles.
- result, cout and ovf hold their last values in IDLE until the next accepted start.
  - On an accepted start, cout and ovf clear to 0.
  - result is overwritten slice by slice, so partial values are visible during RUN; consumers must wait for done.
- Arithmetic is purely modular; there is no saturation.

Test Plan:
- WIDTH=8, add 0x5A+0x3C → at done: result=0x96, cout=0, ovf=1. done rises exactly 5 cycles after the start edge and stays high for 1 cycle; busy is high for 5 cycles.
- Sub 0x10-0x01 → result=0x0F, cout=1, ovf=0. Sub 0x00-0x01 → result=0xFF, cout=0, ovf=0.
- Add 0xFF+0x01 → result=0x00, cout=1, ovf=0. Sub 0x80-0x01 → result=0x7F, cout=1, ovf=1.
- Start add 0x01+0x01, then pulse start with sub=1, a=0xAA during RUN → that start is ignored; result=0x02 and exactly one done pulse occurs.
- Drive rst_n=0 for 1 cycle in the 2nd RUN cycle → next cycle busy=0, done=0, result=0, cout=0, ovf=0. A new start then completes normally with correct values.
- Random sweep, 1000 operations with add/sub and WIDTH=8 and 16 → result, cout and ovf match a reference model. No done pulse ever occurs without a preceding accepted start.

Source files
------------

// File: rtl/serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that works through the operands in
// 2-bit slices, LSB first, and keeps a single carry flip-flop between slices.
module serial_addsub_slice (
    input  logic [1:0] a,
    input  logic [1:0] bb,
    input  logic       cin,
    output logic [1:0] s,
    output logic       c1,
    output logic       cout
);
    // c1 is the carry into bit 1; the top slice uses it for signed overflow
    assign s[0] = a[0] ^ bb[0] ^ cin;
    assign c1   = (a[0] & bb[0]) | (a[0] & cin) | (bb[0] & cin);
    assign s[1] = a[1] ^ bb[1] ^ c1;
    assign cout = (a[1] & bb[1]) | (a[1] & c1) | (bb[1] & c1);
endmodule

module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int SLICES = WIDTH / 2;
    localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [1:0] a_sl, bb_sl, s_sl;
    logic       c_mid, c_out;

    assign a_sl  = a_q[2*idx +: 2];
    assign bb_sl = b_q[2*idx +: 2] ^ {2{sub_q}};

    serial_addsub_slice u_slice (
        .a    (a_sl),
        .bb   (bb_sl),
        .cin  (carry),
        .s    (s_sl),
        .c1   (c_mid),
        .cout (c_out)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        // subtraction is a + ~b + 1: the +1 enters as the initial carry
                        carry <= sub;
                        idx   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[2*idx +: 2] <= s_sl;
                    carry              <= c_out;
                    if (idx == LAST) begin
                        cout  <= c_out;
                        ovf   <= c_mid ^ c_out;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
